// File: rtl/video_capture_writer_pkg.sv
// Shared video definitions: FSM encodings, pixel-word packing and
// saturating position arithmetic, common to capture and display paths.
package video_capture_writer_pkg;

   localparam int unsigned POS_W  = 14;
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned WORD_W = 32;

   typedef logic [POS_W-1:0] pos_t;

   localparam pos_t       POS_MAX = '1;
   localparam logic [7:0] PIX_PAD = 8'h00;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_ACTIVE = 3'd2;
   localparam logic [2:0] ST_DROP   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // 24-bit RGB left-justified in the 32-bit frame-buffer word.
   function automatic logic [WORD_W-1:0] pack_pixel(input logic [PIX_W-1:0] pix);
      return {pix, PIX_PAD};
   endfunction

   // Position counters stick at full scale rather than wrapping.
   function automatic pos_t sat_inc(input pos_t v);
      return (v == POS_MAX) ? v : v + pos_t'(1);
   endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Vsync edge detect plus saturating x/y raster position counters.
module video_pos_counter
   import video_capture_writer_pkg::*;
#(
   parameter bit video_vsync_pol = 1'b1
) (
   input  logic pixel_clock,
   input  logic reset,
   input  logic video_vsync,
   input  logic video_den,
   output logic vs_edge,
   output pos_t x,
   output pos_t y
);

   logic vs_act;
   logic vs_prev_q, vs_prev_d;
   logic den_prev_q, den_prev_d;
   pos_t x_q, x_d;
   pos_t y_q, y_d;

   // Edge detect and next-position computation.
   always_comb begin
      vs_act     = video_vsync ~^ video_vsync_pol;
      vs_edge    = vs_act & ~vs_prev_q;
      vs_prev_d  = vs_act;
      den_prev_d = video_den;
      x_d        = video_den ? sat_inc(x_q) : '0;
      y_d        = y_q;
      if (vs_edge) begin
         y_d = '0;
      end else if (den_prev_q && !video_den) begin
         y_d = sat_inc(y_q);
      end
   end

   // Previous-vsync resets high so a source already in sync gives no edge.
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         vs_prev_q  <= 1'b1;
         den_prev_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         vs_prev_q  <= vs_prev_d;
         den_prev_q <= den_prev_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   assign x = x_q;
   assign y = y_q;

endmodule

// File: rtl/video_capture_writer.sv
// Crops an incoming video stream to source_h x source_v and writes it as
// 32-bit words into the frame-buffer write FIFO, framed by wr_load.
//
// state  | meaning
// IDLE   | after reset, waiting for the first frame edge
// LOAD   | wr_load high for load_len cycles
// ACTIVE | writing cropped pixels of the current frame
// DROP   | frame truncated by FIFO full, waiting for next frame edge
// DONE   | full frame written, waiting for next frame edge
module video_capture_writer
   import video_capture_writer_pkg::*;
#(
   parameter int unsigned source_h        = 800,
   parameter int unsigned source_v        = 480,
   parameter bit          video_vsync_pol = 1'b1,
   parameter int unsigned load_len        = 4
) (
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic              video_vsync,
   input  logic              video_den,
   input  logic [PIX_W-1:0]  video_pixel,
   output logic              wr_load,
   output logic              wr_clk,
   output logic              wrfifo_wren,
   output logic [WORD_W-1:0] wrfifo_din,
   input  logic              wrfifo_full,
   output logic              frame_overflow,
   output logic              frame_done
);

   localparam pos_t       H_LIM     = pos_t'(source_h);
   localparam pos_t       V_LIM     = pos_t'(source_v);
   localparam pos_t       H_LAST    = pos_t'(source_h - 1);
   localparam pos_t       V_LAST    = pos_t'(source_v - 1);
   localparam logic [3:0] LOAD_INIT = 4'(load_len - 1);

   logic vs_edge;
   pos_t x, y;
   logic take, last;

   logic [2:0]        state_q, state_d;
   logic [3:0]        load_cnt_q, load_cnt_d;
   logic              wr_load_q, wr_load_d;
   logic              wren_q, wren_d;
   logic [WORD_W-1:0] din_q, din_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   video_pos_counter #(
      .video_vsync_pol (video_vsync_pol)
   ) u_pos (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .video_vsync (video_vsync),
      .video_den   (video_den),
      .vs_edge     (vs_edge),
      .x           (x),
      .y           (y)
   );

   // Crop window and last-pixel detect from the current raster position.
   always_comb begin
      take = video_den & (x < H_LIM) & (y < V_LIM);
      last = (x == H_LAST) & (y == V_LAST);
   end

   // Frame sequencing; a frame edge always wins and discards that pixel.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      wren_d     = 1'b0;
      din_d      = din_q;
      ovf_d      = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (vs_edge) begin
               state_d    = ST_LOAD;
               load_cnt_d = LOAD_INIT;
            end
         end
         ST_LOAD: begin
            if (vs_edge) begin
               load_cnt_d = LOAD_INIT;
            end else if (load_cnt_q == 4'd0) begin
               state_d = ST_ACTIVE;
            end else begin
               load_cnt_d = load_cnt_q - 4'd1;
            end
         end
         ST_ACTIVE: begin
            if (vs_edge) begin
               state_d    = ST_LOAD;
               load_cnt_d = LOAD_INIT;
            end else if (take) begin
               if (wrfifo_full) begin
                  ovf_d   = 1'b1;
                  state_d = ST_DROP;
               end else begin
                  wren_d = 1'b1;
                  din_d  = pack_pixel(video_pixel);
                  if (last) begin
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DROP, ST_DONE: begin
            if (vs_edge) begin
               state_d    = ST_LOAD;
               load_cnt_d = LOAD_INIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      wr_load_d = (state_d == ST_LOAD);
   end

   // State and registered outputs.
   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         load_cnt_q <= 4'd0;
         wr_load_q  <= 1'b0;
         wren_q     <= 1'b0;
         din_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         wr_load_q  <= wr_load_d;
         wren_q     <= wren_d;
         din_q      <= din_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign wr_clk         = pixel_clock;
   assign wr_load        = wr_load_q;
   assign wrfifo_wren    = wren_q;
   assign wrfifo_din     = din_q;
   assign frame_overflow = ovf_q;
   assign frame_done     = done_q;

endmodule

// File: doc/video_capture_writer.md
# video_capture_writer

Write-side counterpart to the display driver: accepts a pixel-clocked video stream (vsync, data-enable, 24-bit RGB), crops it to a `source_h` × `source_v` window anchored at the top-left, and pushes the pixels as 32-bit words into the frame-buffer write FIFO. Sits between a video source (camera/ISP output) and the DDR frame-buffer write controller. It frames each image with a `wr_load` pulse and drops the remainder of a frame cleanly on FIFO overflow.

## Interface
- `source_h`, 800, pixels per line written to the FIFO (1..16383)
- `source_v`, 480, lines per frame written to the FIFO (1..16383)
- `video_vsync_pol`, 1, active level of `video_vsync` (1 = active-high)
- `load_len`, 4, width in cycles of the `wr_load` pulse (1..15)

Ports:
- `pixel_clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `video_vsync`  in  1  frame sync, polarity per `video_vsync_pol`
- `video_den`  in  1  pixel valid
- `video_pixel`  in  24  RGB, R in [23:16]
- `wr_load`  out  1  write-controller address reset / frame start
- `wr_clk`  out  1  equals `pixel_clock`
- `wrfifo_wren`  out  1  FIFO write enable
- `wrfifo_din`  out  32  `{pixel, 8'h00}`
- `wrfifo_full`  in  1  FIFO full
- `frame_overflow`  out  1  one-cycle pulse when a frame is truncated
- `frame_done`  out  1  one-cycle pulse when `source_h*source_v` pixels are written

## Operation
- `vs_act = video_vsync ~^ video_vsync_pol`. The frame edge `vs_edge` is asserted when `vs_act` is 1 this cycle and was 0 the previous cycle. The previous-value register resets to 1, so a source already in vsync after reset produces no edge.
- Position counters, 14 bits each:
  - `x` increments on each `video_den` cycle and clears on the first cycle with `den` low.
  - `y` increments on the falling edge of `den` and clears on `vs_edge`.
  - Both saturate at 16383 and do not wrap.
- `take = video_den & (x < source_h) & (y < source_v)`.
- FSM states:
  - IDLE: reset state. `vs_edge` → LOAD.
  - LOAD: `wr_load` high, counting `load_len` cycles, then → ACTIVE. A `vs_edge` during LOAD restarts the count.
  - ACTIVE: each `take` cycle writes one word.
    - If `take & wrfifo_full`: that word is not written, `frame_overflow` pulses, → DROP.
    - When the last pixel is written (x = source_h-1, y = source_v-1): `frame_done` pulses, → DONE.
    - `vs_edge` → LOAD. This is a short frame, with no `frame_done` and no `frame_overflow`.
  - DROP, DONE: no writes; `vs_edge` → LOAD.
- Precedence: `vs_edge` overrides `den` in the same cycle, and that pixel is discarded. Reset overrides everything.
- `wrfifo_full` is sampled only in cycles where `take` is high in ACTIVE. Full in any other cycle has no effect.

## Timing
- All outputs are registered except `wr_clk`.
- Reset values: `wr_load`=0, `wrfifo_wren`=0, `wrfifo_din`=0, `frame_overflow`=0, `frame_done`=0. FSM=IDLE, x=y=0.
- Latency from input to FIFO: the pixel sampled at edge N appears on `wrfifo_din` with `wrfifo_wren`=1 after edge N+1.
- `wrfifo_full` is used combinationally against the current `take`. The registered `wren` issued at N+1 therefore reflects full as sampled at N. The FIFO must provide at least 1 word of slack (almost-full style).
- `wr_load` rises the cycle after `vs_edge` is sampled and stays high exactly `load_len` cycles. The first pixel write occurs no earlier than 1 cycle after `wr_load` falls.
- `frame_done` and `frame_overflow` are coincident with the cycle of the last write, or of the dropped write, respectively. They are never asserted together.
- A reset asserted mid-frame clears outputs on the next edge. No write occurs until the next `vs_edge` followed by LOAD.

## Structure
- FSM state encodings (IDLE, LOAD, ACTIVE, DROP, DONE) and the pixel-word packing constant (`8'h00` pad, 24/32 widths) live in the shared video defines include used by the display path.
- One sub-module, `video_pos_counter`: vsync edge detect plus x/y counters with saturation. It is also reusable by the display side.
- The top level holds the FSM, the `load_len` counter, and the output registers.

## Test plan
Unless stated otherwise, benches use `source_h`=4, `source_v`=2, `load_len`=2.

- **Nominal frame.** Stimulus: vsync pulse, then 3 lines of 6 den cycles, pixels 0x000001 upward. Required response: `wr_load` high 2 cycles; 8 writes with `din` = {0x000001..0x000004, 0x000007..0x00000A} << 8; `frame_done` on the 8th write; line 3 ignored.
- **Overflow.** Stimulus: same frame, with `wrfifo_full`=1 while the 3rd pixel is taken. Required response: exactly 2 writes, `frame_overflow` one pulse, no `frame_done`. The next frame writes 8 words normally.
- **Short frame.** Stimulus: vsync after the first line only. Required response: 4 writes, no status pulses, new `wr_load`. The following full frame yields 8 writes.
- **Polarity.** Stimulus: `video_vsync_pol`=0 with an active-low vsync. Required response: identical write sequence to the nominal frame.
- **Reset mid-frame.** Stimulus: `reset` for 1 cycle after the 3rd write. Required response: all outputs 0 the next cycle; den without a preceding vsync produces 0 writes.
- **Simultaneous events.** Stimulus: `vs_edge` coinciding with `den`=1. Required response: no write that cycle, `wr_load` starts next cycle.
